// File: rtl/run_checker.sv
//------------------------------------------------------------------------------
// run_checker
// Runs a processor for a bounded number of cycles, then compares each
// architectural register (1..NREGS-1) against an expected value and reports
// pass/fail with details of the first mismatch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module run_checker #(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int ADDR_W     = 5,
  parameter int CYC_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic              halt_en,
  input  logic [DATA_W-1:0] pc_in,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_act,
  output logic [DATA_W-1:0] fail_exp,
  output logic [CYC_W-1:0]  cycles_run
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  // The register index must be able to address every architectural register.
  if (2**ADDR_W < NREGS) begin : g_bad_addr_w
    $error("run_checker: ADDR_W too small for NREGS");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    SCAN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                have_prev_q;
  logic [DATA_W-1:0]   prev_pc_q;
  logic                cpu_reset_q;
  logic                cpu_en_q;
  logic [ADDR_W-1:0]   reg_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                timed_out_q;
  logic [ADDR_W:0]     err_count_q;
  logic [ADDR_W-1:0]   fail_idx_q;
  logic [DATA_W-1:0]   fail_act_q;
  logic [DATA_W-1:0]   fail_exp_q;
  logic [CYC_W-1:0]    cycles_run_q;

  logic [CYC_W-1:0]    cycles_d;
  logic [CYC_W-1:0]    budget_d;
  logic                halt_hit_d;
  logic                budget_hit_d;
  logic                mismatch_d;
  logic [ADDR_W:0]     err_inc_d;
  logic                last_reg_d;

  // Next-value helpers: run counter, exit conditions and scan comparison.
  always_comb begin
    cycles_d     = cycles_run_q + 1'b1;
    // A zero budget still runs the processor for one clock.
    budget_d     = (max_cycles == '0) ? CYC_W'(1) : max_cycles;
    // have_prev_q keeps the first RUN clock from ever matching.
    halt_hit_d   = halt_en && have_prev_q && (pc_in == prev_pc_q);
    budget_hit_d = (cycles_d >= budget_d);
    mismatch_d   = (reg_data != exp_data);
    err_inc_d    = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
    last_reg_d   = (reg_addr_q == ADDR_W'(NREGS - 1));
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      have_prev_q  <= 1'b0;
      prev_pc_q    <= '0;
      cpu_reset_q  <= 1'b1;
      cpu_en_q     <= 1'b0;
      reg_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      err_count_q  <= '0;
      fail_idx_q   <= '0;
      fail_act_q   <= '0;
      fail_exp_q   <= '0;
      cycles_run_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= HOLD;
            hold_q       <= '0;
            have_prev_q  <= 1'b0;
            prev_pc_q    <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_en_q     <= 1'b0;
            reg_addr_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            err_count_q  <= '0;
            fail_idx_q   <= '0;
            fail_act_q   <= '0;
            fail_exp_q   <= '0;
            cycles_run_q <= '0;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
            cpu_en_q    <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RUN: begin
          cycles_run_q <= cycles_d;
          prev_pc_q    <= pc_in;
          have_prev_q  <= 1'b1;
          // Halt takes priority, so a coincident budget exit is not a timeout.
          if (halt_hit_d || budget_hit_d) begin
            state_q     <= SCAN;
            cpu_en_q    <= 1'b0;
            reg_addr_q  <= ADDR_W'(1);
            timed_out_q <= ~halt_hit_d;
          end
        end
        SCAN: begin
          if (mismatch_d) begin
            err_count_q <= err_inc_d;
            // err_count saturates and never returns to zero, so this marks the first miss.
            if (err_count_q == '0) begin
              fail_idx_q <= reg_addr_q;
              fail_act_q <= reg_data;
              fail_exp_q <= exp_data;
            end
          end
          if (last_reg_d) begin
            state_q    <= DONE;
            reg_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= (err_count_q == '0) && !mismatch_d;
          end else begin
            reg_addr_q <= reg_addr_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cpu_reset_q <= 1'b1;
          cpu_en_q    <= 1'b0;
          reg_addr_q  <= '0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign cpu_en     = cpu_en_q;
  assign reg_addr   = reg_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timed_out  = timed_out_q;
  assign err_count  = err_count_q;
  assign fail_idx   = fail_idx_q;
  assign fail_act   = fail_act_q;
  assign fail_exp   = fail_exp_q;
  assign cycles_run = cycles_run_q;

endmodule

`default_nettype wire

// File: tb/tb_run_checker.sv
//------------------------------------------------------------------------------
// tb_run_checker
// Directed bench for run_checker with a small register file / expected table.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_checker;

  localparam int DATA_W     = 32;
  localparam int NREGS      = 4;
  localparam int ADDR_W     = 2;
  localparam int CYC_W      = 16;
  localparam int RST_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CYC_W-1:0]  max_cycles;
  logic              halt_en;
  logic [DATA_W-1:0] pc_in;
  logic              cpu_reset;
  logic              cpu_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] exp_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] fail_idx;
  logic [DATA_W-1:0] fail_act;
  logic [DATA_W-1:0] fail_exp;
  logic [CYC_W-1:0]  cycles_run;

  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] ex [NREGS];
  logic [DATA_W-1:0] pc_tab [8];

  int checks = 0;
  int errors = 0;
  int rst_n, en_n, scan_n, pc_idx;
  bit inject_scan_start;

  assign reg_data = rf[reg_addr];
  assign exp_data = ex[reg_addr];

  always #5 clk = ~clk;

  run_checker #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
    .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
    .halt_en(halt_en), .pc_in(pc_in), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
    .reg_addr(reg_addr), .reg_data(reg_data), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .err_count(err_count), .fail_idx(fail_idx), .fail_act(fail_act),
    .fail_exp(fail_exp), .cycles_run(cycles_run)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then follow the run to DONE, counting phase lengths.
  task automatic do_run(input int budget);
    int n;
    bit injected;
    rst_n = 0; en_n = 0; scan_n = 0; pc_idx = 0; injected = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_done_clr", {63'd0, done}, 64'd0);
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_cyc_clr", {48'd0, cycles_run}, 64'd0);
    chk("start_err_clr", {61'd0, err_count}, 64'd0);
    n = 0;
    while (n < budget && !done) begin
      if (cpu_reset && busy) rst_n++;
      if (cpu_en) begin
        en_n++;
        pc_in = pc_tab[(pc_idx < 8) ? pc_idx : 7];
        pc_idx++;
      end
      if (busy && reg_addr != '0) begin
        scan_n++;
        if (inject_scan_start && !injected && reg_addr == ADDR_W'(1)) begin
          start = 1'b1;
          injected = 1;
        end
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("run_reached_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    pc_tab = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hc, 32'h10, 32'h14, 32'h18};
    for (int i = 0; i < NREGS; i++) begin
      rf[i] = 32'h1111_0000 + i;
      ex[i] = 32'h1111_0000 + i;
    end
    reset = 1'b1; start = 1'b0; max_cycles = '0; halt_en = 1'b0; pc_in = '0;
    inject_scan_start = 0;
    tick();
    tick();

    // Reset state
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_reg_addr", {62'd0, reg_addr}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_cpu_reset", {63'd0, cpu_reset}, 64'd1);

    // All registers match, budget exit after 5 clocks
    max_cycles = 16'd5;
    do_run(100);
    chk("t1_hold_len", rst_n, 2);
    chk("t1_run_len", en_n, 5);
    chk("t1_scan_len", scan_n, 3);
    chk("t1_pass", {63'd0, pass}, 64'd1);
    chk("t1_timed_out", {63'd0, timed_out}, 64'd1);
    chk("t1_cycles_run", {48'd0, cycles_run}, 64'd5);
    chk("t1_err_count", {61'd0, err_count}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    chk("t1_reg_addr", {62'd0, reg_addr}, 64'd0);
    tick();
    chk("t1_done_holds", {63'd0, done}, 64'd1);

    // Registers 2 and 3 mismatch
    rf[2] = 32'hcafe_babe; ex[2] = 32'h0000_0001;
    rf[3] = 32'h0000_0005; ex[3] = 32'h0000_0006;
    do_run(100);
    chk("t2_err_count", {61'd0, err_count}, 64'd2);
    chk("t2_fail_idx", {62'd0, fail_idx}, 64'd2);
    chk("t2_fail_act", {32'd0, fail_act}, 64'hcafe_babe);
    chk("t2_fail_exp", {32'd0, fail_exp}, 64'h1);
    chk("t2_pass", {63'd0, pass}, 64'd0);
    chk("t2_timed_out", {63'd0, timed_out}, 64'd1);

    // Only the last register mismatches: final comparison must affect pass
    rf[2] = ex[2];
    do_run(100);
    chk("t2b_pass", {63'd0, pass}, 64'd0);
    chk("t2b_err_count", {61'd0, err_count}, 64'd1);
    chk("t2b_fail_idx", {62'd0, fail_idx}, 64'd3);
    rf[3] = ex[3];

    // Halt on PC self-loop: 0,4,8,8
    halt_en = 1'b1; max_cycles = 16'd100;
    do_run(200);
    chk("t3_run_len", en_n, 4);
    chk("t3_cycles_run", {48'd0, cycles_run}, 64'd4);
    chk("t3_timed_out", {63'd0, timed_out}, 64'd0);
    chk("t3_pass", {63'd0, pass}, 64'd1);

    // Halt and budget coincide: halt wins
    max_cycles = 16'd4;
    do_run(100);
    chk("t3b_cycles_run", {48'd0, cycles_run}, 64'd4);
    chk("t3b_timed_out", {63'd0, timed_out}, 64'd0);

    // Zero budget runs one clock; start during SCAN ignored
    halt_en = 1'b0; max_cycles = 16'd0; inject_scan_start = 1;
    do_run(100);
    inject_scan_start = 0;
    chk("t4_run_len", en_n, 1);
    chk("t4_cycles_run", {48'd0, cycles_run}, 64'd1);
    chk("t4_timed_out", {63'd0, timed_out}, 64'd1);
    chk("t4_scan_len", scan_n, 3);
    chk("t4_pass", {63'd0, pass}, 64'd1);

    // Start in DONE begins a new run; reset together with start mid-RUN aborts it
    max_cycles = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_done_clr", {63'd0, done}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd1);
    begin
      int n = 0;
      while (!cpu_en && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t5_in_run", {63'd0, cpu_en}, 64'd1);
    tick();
    tick();
    chk("t5_cycles_mid", {48'd0, cycles_run}, 64'd2);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("t5_rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("t5_rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    chk("t5_rst_pass", {63'd0, pass}, 64'd0);
    chk("t5_rst_timed_out", {63'd0, timed_out}, 64'd0);
    chk("t5_rst_err_count", {61'd0, err_count}, 64'd0);
    chk("t5_rst_fail_idx", {62'd0, fail_idx}, 64'd0);
    chk("t5_rst_fail_act", {32'd0, fail_act}, 64'd0);
    chk("t5_rst_fail_exp", {32'd0, fail_exp}, 64'd0);
    chk("t5_rst_cycles", {48'd0, cycles_run}, 64'd0);
    chk("t5_rst_reg_addr", {62'd0, reg_addr}, 64'd0);
    tick();
    chk("t5_idle_busy", {63'd0, busy}, 64'd0);
    chk("t5_idle_cpu_reset", {63'd0, cpu_reset}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_checker.md
RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 The module SHALL have parameter DATA_W, 32, width of the register and expected-value data.
REQ-002 The module SHALL have parameter NREGS, 32, number of architectural registers; register 0 is never checked.
REQ-003 The module SHALL have parameter ADDR_W, 5, register index width, and SHALL require 2**ADDR_W >= NREGS.
REQ-004 The module SHALL have parameter CYC_W, 16, width of the cycle counters.
REQ-005 The module SHALL have parameter RST_CYCLES, 2, number of clocks the processor reset is held after start.
REQ-006 The module SHALL have these ports, in this order:
 clk  in  1  single clock; all state changes on its rising edge.
 reset  in  1  synchronous, active-high reset.
 start  in  1  one-cycle request to begin a run.
 max_cycles  in  CYC_W  processor cycle budget.
 halt_en  in  1  1 = end RUN early on PC self-loop.
 pc_in  in  DATA_W  processor PC.
 cpu_reset  out  1  drives processor reset.
 cpu_en  out  1  processor clock enable.
 reg_addr  out  ADDR_W  register-file and expected-memory read index.
 reg_data  in  DATA_W  register-file read data, combinational in reg_addr.
 exp_data  in  DATA_W  expected value, combinational in reg_addr.
 busy  out  1  high in HOLD, RUN or SCAN.
 done  out  1  high in DONE.
 pass  out  1  valid while done.
 timed_out  out  1  RUN ended by budget, not by halt.
 err_count  out  ADDR_W+1  number of mismatching registers.
 fail_idx  out  ADDR_W  first mismatching index.
 fail_act  out  DATA_W  actual value at fail_idx.
 fail_exp  out  DATA_W  expected value at fail_idx.
 cycles_run  out  CYC_W  RUN cycles executed.

Function
REQ-007 The FSM SHALL have states IDLE, HOLD, RUN, SCAN and DONE, in a registered state variable.
REQ-008 On start in IDLE or DONE, the FSM SHALL enter HOLD and clear done, pass, timed_out, err_count, fail_* and cycles_run.
REQ-009 The block SHALL ignore start in HOLD, RUN or SCAN.
REQ-010 HOLD SHALL last exactly RST_CYCLES clocks with cpu_reset=1 and cpu_en=0, then the FSM SHALL enter RUN.
REQ-011 cpu_reset SHALL be 1 in IDLE and HOLD and 0 otherwise.
REQ-012 cpu_en SHALL be 1 only in RUN.
REQ-013 In RUN, cycles_run SHALL increment by 1 every clock.
REQ-014 RUN SHALL end after exactly max_cycles clocks, with max_cycles=0 treated as 1; on that exit timed_out SHALL be set to 1.
REQ-015 If halt_en=1, RUN SHALL end when pc_in equals the pc_in sampled on the previous RUN clock; the first RUN clock never matches.
REQ-016 If the halt and budget conditions coincide, the halt condition SHALL win and timed_out SHALL be 0.
REQ-017 On leaving RUN, reg_addr SHALL be set to 1 and the FSM SHALL enter SCAN.
REQ-018 Each SCAN clock SHALL compare reg_data against exp_data and increment reg_addr.
REQ-019 On each mismatch, err_count SHALL increment, saturating at 2**(ADDR_W+1)-1.
REQ-020 On the first mismatch only, the block SHALL latch fail_idx=reg_addr, fail_act=reg_data and fail_exp=exp_data.
REQ-021 SCAN SHALL check indices 1..NREGS-1, taking exactly NREGS-1 clocks, and then enter DONE.
REQ-022 On entering DONE, pass SHALL equal (err_count==0) including the final comparison.
REQ-023 In DONE, done SHALL be 1 and all result outputs SHALL hold until start or reset.
REQ-024 reg_addr SHALL be 0 outside SCAN.

Reset
REQ-025 Synchronous reset SHALL force state=IDLE, cpu_reset=1, cpu_en=0, reg_addr=0, and set busy, done, pass, timed_out, err_count, fail_idx, fail_act, fail_exp and cycles_run to 0.
REQ-026 Reset SHALL take priority over start in the same cycle.
REQ-027 Reset asserted in any state mid-run SHALL abort the run, with no partial result reported.

Verification
REQ-028 Bench SHALL cover: NREGS=4, RST_CYCLES=2, max_cycles=5, halt_en=0, all registers match -> cpu_reset high 2 clocks, cpu_en high 5 clocks, SCAN 3 clocks, done=1, pass=1, timed_out=1, cycles_run=5.
REQ-029 Bench SHALL cover: regs 2 and 3 mismatch (reg2=cafebabe, exp=00000001) -> err_count=2, fail_idx=2, fail_act=cafebabe, fail_exp=00000001, pass=0.
REQ-030 Bench SHALL cover: halt_en=1, pc_in 0,4,8,8, max_cycles=100 -> RUN ends after the 4th clock, cycles_run=4, timed_out=0.
REQ-031 Bench SHALL cover: max_cycles=0 -> exactly 1 RUN clock; then start pulsed during SCAN -> ignored; then start in DONE -> new run, done cleared next clock.
REQ-032 Bench SHALL cover: reset asserted mid-RUN together with start -> IDLE, all outputs at reset values, cpu_reset=1.
